// File: rtl/adder_32bit_pkg.sv
// adder_32bit_pkg: binary32 field layout, special constants and operand unpacking
package adder_32bit_pkg;
  localparam int WIDTH = 32;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W = FRAC_W + 1;
  localparam int SIGN_POS = 31;
  localparam int EXP_LSB = FRAC_W;
  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [WIDTH-1:0] QNAN = 32'h7FC00000;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_t;
  // subnormals take effective exponent 1 with the hidden bit clear
  function automatic fp_t unpack(input logic [WIDTH-1:0] x);
    logic [EXP_W-1:0] e;
    logic [FRAC_W-1:0] f;
    e = x[SIGN_POS-1:EXP_LSB];
    f = x[FRAC_W-1:0];
    unpack.sign = x[SIGN_POS];
    unpack.exp = e == '0 ? 8'd1 : e;
    unpack.sig = {e != '0, f};
    unpack.is_zero = e == '0 && f == '0;
    unpack.is_inf = e == EXP_MAX && f == '0;
    unpack.is_nan = e == EXP_MAX && f != '0;
  endfunction
endpackage

// File: rtl/adder_32bit_lzc28.sv
// fp_lzc28: leading-zero count of a 28-bit vector (28 when all zero)
module fp_lzc28 (
  input  logic [27:0] value,
  output logic [4:0]  count
);
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++)
      if (value[i]) count = 5'(27 - i);
  end
endmodule

// File: rtl/adder_32bit.sv
// adder_32bit: 3-stage pipelined IEEE-754 binary32 adder, round-to-nearest-even
module adder_32bit
  import adder_32bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F
);
  fp_t ua, ub;
  logic swap, b_sign, sub, zsign, spec;
  logic [EXP_W-1:0] b_exp, s_exp;
  logic [SIG_W-1:0] b_sig, s_sig;
  logic [WIDTH-1:0] sval;
  always_comb begin
    ua = unpack(A);
    ub = unpack(B);
    swap = B[SIGN_POS-1:0] > A[SIGN_POS-1:0];
    b_sign = swap ? ub.sign : ua.sign;
    b_exp = swap ? ub.exp : ua.exp;
    s_exp = swap ? ua.exp : ub.exp;
    b_sig = swap ? ub.sig : ua.sig;
    s_sig = swap ? ua.sig : ub.sig;
    sub = ua.sign ^ ub.sign;
    zsign = ua.is_zero & ub.is_zero & ua.sign & ub.sign;
    spec = ua.is_nan | ub.is_nan | ua.is_inf | ub.is_inf;
    sval = (ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & sub)) ? QNAN :
           {ua.is_inf ? ua.sign : ub.sign, EXP_MAX, {FRAC_W{1'b0}}};
  end
  logic s1_sign, s1_sub, s1_zsign, s1_spec;
  logic [EXP_W-1:0] s1_exp, s1_diff;
  logic [SIG_W-1:0] s1_sig, s1_ssig;
  logic [WIDTH-1:0] s1_sval;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {s1_sign, s1_sub, s1_zsign, s1_spec} <= '0;
      {s1_exp, s1_diff, s1_sig, s1_ssig, s1_sval} <= '0;
    end else begin
      {s1_sign, s1_sub, s1_zsign, s1_spec} <= {b_sign, sub, zsign, spec};
      {s1_exp, s1_diff} <= {b_exp, b_exp - s_exp};
      {s1_sig, s1_ssig, s1_sval} <= {b_sig, s_sig, sval};
    end
  end
  // over-long shifts empty the aligned value and the mask, so everything lands in sticky
  logic [26:0] sm_ext, shifted, aligned;
  logic [27:0] sum;
  always_comb begin
    sm_ext = {s1_ssig, 3'b000};
    shifted = sm_ext >> s1_diff;
    aligned = {shifted[26:1], shifted[0] | (|(sm_ext & ~({27{1'b1}} << s1_diff)))};
    sum = s1_sub ? {1'b0, s1_sig, 3'b000} - {1'b0, aligned} : {1'b0, s1_sig, 3'b000} + {1'b0, aligned};
  end
  logic s2_sign, s2_spec;
  logic [EXP_W-1:0] s2_exp;
  logic [27:0] s2_sum;
  logic [WIDTH-1:0] s2_sval;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {s2_sign, s2_spec, s2_exp, s2_sum, s2_sval} <= '0;
    end else begin
      s2_sign <= sum == '0 ? s1_zsign : s1_sign;
      {s2_spec, s2_exp, s2_sum, s2_sval} <= {s1_spec, s1_exp, sum, s1_sval};
    end
  end
  logic [4:0] lzc;
  fp_lzc28 u_lzc (.value(s2_sum), .count(lzc));
  // left shift stops at exponent 1 so tiny results come out subnormal
  logic [9:0] lz1, em1, sh, e, fe;
  logic [26:0] n;
  logic [24:0] rnd;
  logic up, ovf;
  logic [WIDTH-1:0] res;
  always_comb begin
    lz1 = {5'd0, lzc} - 10'd1;
    em1 = {2'd0, s2_exp} - 10'd1;
    sh = lz1 < em1 ? lz1 : em1;
    n = s2_sum[27] ? {s2_sum[27:2], |s2_sum[1:0]} : s2_sum[26:0] << sh;
    e = s2_sum[27] ? {2'd0, s2_exp} + 10'd1 : {2'd0, s2_exp} - sh;
    up = n[2] & (n[1] | n[0] | n[3]);
    rnd = {1'b0, n[26:3]} + {24'd0, up};
    fe = rnd[24] ? e + 10'd1 : e;
    ovf = fe >= 10'd255;
    res = s2_spec ? s2_sval :
          s2_sum == '0 ? {s2_sign, 31'd0} :
          ovf ? {s2_sign, EXP_MAX, {FRAC_W{1'b0}}} :
          {s2_sign, (rnd[24] | rnd[23]) ? fe[7:0] : 8'd0, rnd[24] ? rnd[23:1] : rnd[22:0]};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) F <= '0;
    else F <= res;
  end
endmodule

// File: tb/tb_adder_32bit.sv
// tb_adder_32bit: directed and random stream against an exact wide-integer reference
module tb_adder_32bit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [31:0] F;
  int n_checks = 0, n_fail = 0;
  logic [31:0] eq[$];
  string tq[$];

  adder_32bit dut (.clk(clk), .rst(rst), .A(A), .B(B), .F(F));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [299:0] mag(input logic [31:0] x);
    logic [299:0] m;
    m = {276'd0, x[30:23] != 8'd0, x[22:0]};
    return x[30:23] == 8'd0 ? m : m << (x[30:23] - 8'd1);
  endfunction

  // exact sum as integer multiple of 2^-149, then a single RNE rounding
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] ma, mb, m, keep, rem, half, one;
    logic [24:0] kp;
    logic s;
    int p, sh;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 32'h7FC00000;
    if (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000) return a[31] == b[31] ? a : 32'h7FC00000;
    if (a[30:0] == 31'h7F800000) return a;
    if (b[30:0] == 31'h7F800000) return b;
    ma = mag(a);
    mb = mag(b);
    if (a[31] == b[31]) begin m = ma + mb; s = a[31]; end
    else if (ma >= mb) begin m = ma - mb; s = a[31]; end
    else begin m = mb - ma; s = b[31]; end
    if (m == 0) s = (a[31] == b[31]) ? a[31] : 1'b0;
    p = -1;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    if (p <= 23) return {s, m[30:0]};
    one = 300'd1;
    sh = p - 23;
    keep = m >> sh;
    rem = m & ((one << sh) - one);
    half = one << (sh - 1);
    kp = keep[24:0];
    if (rem > half || (rem == half && kp[0])) kp = kp + 25'd1;
    if (kp[24]) begin kp = kp >> 1; sh++; end
    if (sh + 1 >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(sh + 1), kp[22:0]};
  endfunction

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input string tag);
    A = a;
    B = b;
    @(posedge clk);
    eq.push_back(exp);
    tq.push_back(tag);
    #1;
    if (eq.size() == 3) check(tq.pop_front(), F, eq.pop_front());
    else check("post_rst", F, 32'd0);
  endtask

  logic [31:0] da[15] = '{32'h00000000, 32'h00000010, 32'h000000F0, 32'h0000C000, 32'h00009000, 32'h00000003,
                          32'h3F800000, 32'h3FC00000, 32'h00400000, 32'h3F800000,
                          32'h3F800000, 32'h80000000, 32'h7F800000, 32'h7FC00001, 32'h7F800000};
  logic [31:0] db[15] = '{32'h00000001, 32'h00000001, 32'h00000040, 32'h00001000, 32'h00008000, 32'h00000001,
                          32'h3F800000, 32'hBF800000, 32'h00400000, 32'h33800000,
                          32'hBF800000, 32'h80000000, 32'hFF800000, 32'h3F800000, 32'h3F800000};
  logic [31:0] df[15] = '{32'h00000001, 32'h00000011, 32'h00000130, 32'h0000D000, 32'h00011000, 32'h00000004,
                          32'h40000000, 32'h3F000000, 32'h00800000, 32'h3F800000,
                          32'h00000000, 32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000};

  task automatic rand_step();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 5))
      0: b[30:23] = a[30:23];
      1: b = {~a[31], a[30:0] ^ 31'($urandom_range(0, 7))};
      2: begin a[30:23] = 8'd0; b[30:23] = 8'($urandom_range(0, 2)); end
      3: b[30:23] = a[30:23] - 8'($urandom_range(20, 30));
      4: begin a[30:23] = 8'hFE; b[30:23] = 8'($urandom_range(250, 255)); end
      default: ;
    endcase
    step(a, b, ref_add(a, b), "rnd");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset", F, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) step(da[i], db[i], df[i], "dir");
    step(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "ovf");
    for (int i = 0; i < 1000; i++) rand_step();
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", F, 32'd0);
    eq.delete();
    tq.delete();
    @(posedge clk);
    #1;
    check("rst_hold", F, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 1000; i++) rand_step();
    for (int i = 0; i < 3; i++) step(32'd0, 32'd0, 32'd0, "flush");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
